load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 211 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store unit for a word-organised data memory.
// Accepts one request at a time, checks alignment, runs a short FSM
// (IDLE / READ / WRITE / RESP) and returns a response through a
// valid/ready handshake. Loads are lane-extracted and sign/zero extended.
// Optional feature macro: LSU_RMW_EN -- when defined, aligned half/byte
// stores are done as read-modify-write of the whole word; when undefined,
// sub-word stores are only legal at byte offset 0 and use the memory's
// half-low/byte-low write modes.
module load_store_unit (
  input  logic        clk,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqData,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspData,
  output logic        misaligned,
  output logic        stall,
  output logic [31:0] memAddress,
  output logic [31:0] memDataIn,
  output logic [1:0]  memWrite,
  output logic        memRead,
  input  logic [31:0] memData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_reg, state_next;
  logic        ready_en_reg;
  logic [1:0]  offset_reg;
  logic [1:0]  size_reg;
  logic        signed_reg;
  logic        write_reg;
  logic        misaligned_reg;
  logic [31:0] address_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;

  logic        accept;
  logic        bad_align;
  logic [31:0] store_word;
  logic [31:0] lane_shift;
  logic [31:0] load_val;
  logic [1:0]  write_code;

  assign accept = reqValid & reqReady;

  // Alignment check of the incoming request.
  always_comb begin
    bad_align = 1'b0;
    case (reqSize)
      2'b01:   bad_align = (reqAddr[1:0] != 2'b00);
      2'b10:   bad_align = reqAddr[0];
      2'b11:   bad_align = 1'b0;
      default: bad_align = 1'b1;
    endcase
`ifndef LSU_RMW_EN
    // Without read-modify-write the memory can only write the low lanes.
    if (reqWrite && reqSize[1] && (reqAddr[1:0] != 2'b00))
      bad_align = 1'b1;
`endif
  end

  // Store data trimmed to the access size (sub-word data sits in the low bits).
  always_comb begin
    case (reqSize)
      2'b10:   store_word = {16'h0000, reqData[15:0]};
      2'b11:   store_word = {24'h000000, reqData[7:0]};
      default: store_word = reqData;
    endcase
  end

  // Load extraction: shift the addressed lane down, then extend.
  assign lane_shift = memData >> {offset_reg, 3'b000};

  always_comb begin
    case (size_reg)
      2'b10:   load_val = {{16{signed_reg & lane_shift[15]}}, lane_shift[15:0]};
      2'b11:   load_val = {{24{signed_reg & lane_shift[7]}}, lane_shift[7:0]};
      default: load_val = memData;
    endcase
  end

`ifdef LSU_RMW_EN
  logic [3:0]  lane_en;
  logic [31:0] lane_src;
  logic [31:0] merged;

  // Byte-lane enables and replicated store data for the merge.
  always_comb begin
    case (size_reg)
      2'b10:   lane_en = offset_reg[1] ? 4'b1100 : 4'b0011;
      2'b11:   lane_en = 4'b0001 << offset_reg;
      default: lane_en = 4'b1111;
    endcase
    lane_src = (size_reg == 2'b11) ? {4{wdata_reg[7:0]}} : {2{wdata_reg[15:0]}};
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = lane_en[gi] ? lane_src[8*gi +: 8] : memData[8*gi +: 8];
    end
  endgenerate

  assign write_code = 2'b01;
`else
  // Write mode follows the access size: 01 word, 10 half-low, 11 byte-low.
  assign write_code = size_reg;
`endif

  // FSM state register; reset abandons any transaction at once.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg    <= IDLE;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
    end
  end

  // FSM next-state and handshake/memory control outputs.
  always_comb begin
    state_next = state_reg;
    reqReady   = 1'b0;
    stall      = 1'b1;
    rspValid   = 1'b0;
    memRead    = 1'b0;
    memWrite   = 2'b00;
    memDataIn  = 32'h0;
    case (state_reg)
      IDLE: begin
        stall    = 1'b0;
        reqReady = ready_en_reg;
        if (accept) begin
          if (bad_align)
            state_next = RESP;
          else if (!reqWrite)
            state_next = READ;
          else if (reqSize == 2'b01)
            state_next = WRITE;
          else begin
`ifdef LSU_RMW_EN
            state_next = READ;
`else
            state_next = WRITE;
`endif
          end
        end
      end
      READ: begin
        memRead    = 1'b1;
        state_next = write_reg ? WRITE : RESP;
      end
      WRITE: begin
        memWrite   = write_code;
        memDataIn  = wdata_reg;
        state_next = RESP;
      end
      RESP: begin
        rspValid = 1'b1;
        if (rspReady)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture on acceptance, and load/merge capture at the end of READ.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      offset_reg     <= 2'b00;
      size_reg       <= 2'b00;
      signed_reg     <= 1'b0;
      write_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
      address_reg    <= 32'h0;
      wdata_reg      <= 32'h0;
      rdata_reg      <= 32'h0;
    end else if (accept) begin
      offset_reg     <= reqAddr[1:0];
      size_reg       <= reqSize;
      signed_reg     <= reqSigned;
      write_reg      <= reqWrite;
      misaligned_reg <= bad_align;
      address_reg    <= {2'b00, reqAddr[31:2]};
      wdata_reg      <= store_word;
      rdata_reg      <= 32'h0;
    end else if (state_reg == READ) begin
`ifdef LSU_RMW_EN
      if (write_reg)
        wdata_reg <= merged;
      else
        rdata_reg <= load_val;
`else
      rdata_reg <= load_val;
`endif
    end
  end

  assign memAddress = address_reg;
  assign rspData    = rspValid ? rdata_reg : 32'h0;
  assign misaligned = rspValid & misaligned_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit with a word memory,
// a behavioural request model and one per-cycle compare process.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        resetN;
  logic        reqValid, reqReady, reqWrite, reqSigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqData;
  logic        rspValid, rspReady, misaligned, stall, memRead;
  logic [31:0] rspData, memAddress, memDataIn, memData;
  logic [1:0]  memWrite;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] ram       [0:63];
  logic [31:0] model_mem [0:63];

  // Expectations for the transaction in flight.
  logic        live = 1'b0;
  logic        active = 1'b0;
  logic        seen;
  int          acc_cyc, rd_cnt, wr_cnt;
  int          exp_lat, exp_rd, exp_wr;
  logic [31:0] exp_data;
  logic        exp_mis;
  logic [1:0]  exp_wcode;
  logic [5:0]  exp_idx;

  load_store_unit dut (
    .clk(clk), .resetN(resetN),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqData(reqData),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
    .misaligned(misaligned), .stall(stall),
    .memAddress(memAddress), .memDataIn(memDataIn), .memWrite(memWrite),
    .memRead(memRead), .memData(memData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: combinational read, lane writes on the clock edge.
  assign memData = ram[memAddress[5:0]];
  always @(posedge clk) begin
    case (memWrite)
      2'b01: ram[memAddress[5:0]]       <= memDataIn;
      2'b10: ram[memAddress[5:0]][15:0] <= memDataIn[15:0];
      2'b11: ram[memAddress[5:0]][7:0]  <= memDataIn[7:0];
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Per-cycle compare of DUT outputs against the model expectations.
  always @(negedge clk) begin
    if (resetN && live) begin
      chk("stall_vs_ready", {31'b0, stall}, {31'b0, ~reqReady});
      if (!active) begin
        chk("idle_no_mem", {29'b0, memRead, memWrite}, 32'h0);
      end else begin
        if (memRead) rd_cnt++;
        if (memWrite != 2'b00) begin
          wr_cnt++;
          chk("write_code", {30'b0, memWrite}, {30'b0, exp_wcode});
        end
        if (memRead || memWrite != 2'b00)
          chk("mem_address", memAddress, {26'b0, exp_idx});
        if (rspValid) begin
          if (!seen) begin
            seen = 1'b1;
            chk("latency", cyc - acc_cyc, exp_lat);
            chk("read_cycles", rd_cnt, exp_rd);
            chk("write_cycles", wr_cnt, exp_wr);
            chk("mem_word", ram[exp_idx], model_mem[exp_idx]);
          end
          chk("rsp_data", rspData, exp_data);
          chk("rsp_misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
          chk("resp_stall", {31'b0, stall}, 32'h1);
          chk("resp_ready_low", {31'b0, reqReady}, 32'h0);
        end
      end
    end
  end

  // Issue one request, model it from the access rules, wait for and retire the response.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        input int hold, input logic noise,
                        output logic [31:0] got, output logic got_mis);
    logic [31:0] old, shifted, mask, v;
    logic        b;
    int          n;
    case (sz)
      2'b01:   b = (a[1:0] != 2'b00);
      2'b10:   b = a[0];
      2'b11:   b = 1'b0;
      default: b = 1'b1;
    endcase
`ifndef LSU_RMW_EN
    if (w && sz != 2'b01 && a[1:0] != 2'b00) b = 1'b1;
`endif
    exp_idx   = a[7:2];
    exp_mis   = b;
    exp_data  = 32'h0;
    exp_rd    = 0;
    exp_wr    = 0;
    exp_lat   = 1;
`ifdef LSU_RMW_EN
    exp_wcode = 2'b01;
`else
    exp_wcode = sz;
`endif
    old     = model_mem[exp_idx];
    shifted = old >> (8 * a[1:0]);
    if (!b && !w) begin
      if (sz == 2'b01) v = old;
      else if (sz == 2'b10) begin
        v = shifted & 32'hFFFF;
        if (sg && v[15]) v = v | 32'hFFFF0000;
      end else begin
        v = shifted & 32'hFF;
        if (sg && v[7]) v = v | 32'hFFFFFF00;
      end
      exp_data = v;
      exp_rd   = 1;
      exp_lat  = 2;
    end else if (!b && w) begin
      mask = (sz == 2'b01) ? 32'hFFFFFFFF :
             (sz == 2'b10) ? (32'hFFFF << (8 * a[1:0])) : (32'hFF << (8 * a[1:0]));
      model_mem[exp_idx] = (old & ~mask) | ((d << (8 * a[1:0])) & mask);
      exp_wr  = 1;
`ifdef LSU_RMW_EN
      exp_rd  = (sz != 2'b01) ? 1 : 0;
`endif
      exp_lat = 2 + exp_rd;
    end

    @(negedge clk); #2;
    chk("ready_before_req", {31'b0, reqReady}, 32'h1);
    reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqData = d;
    reqValid = 1'b1;
    acc_cyc = cyc; rd_cnt = 0; wr_cnt = 0; seen = 1'b0; active = 1'b1;
    @(posedge clk); #1;
    if (noise) begin
      // A competing store while busy must be ignored.
      reqWrite = 1'b1; reqSize = 2'b01; reqAddr = {a[31:2], 2'b00}; reqData = 32'h0BAD0BAD;
    end else begin
      reqValid = 1'b0;
    end
    n = 0;
    while (!rspValid && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
    got = rspData;
    got_mis = misaligned;
    if (!rspValid) begin
      total++; bad++;
      $display("FAIL rsp_timeout actual=no_rspValid required=rspValid addr=%h", a);
      reqValid = 1'b0;
      active = 1'b0;
    end else begin
      repeat (hold) @(negedge clk);
      @(negedge clk); #2;
      reqValid = 1'b0;
      rspReady = 1'b1;
      @(posedge clk); #1;
      rspReady = 1'b0;
      active = 1'b0;
      chk("ready_after_retire", {31'b0, reqReady}, 32'h1);
    end
  endtask

  logic [31:0] got;
  logic        gm;
  int          rv_cnt;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    resetN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqSigned = 1'b0;
    reqAddr = 32'h0; reqData = 32'h0; rspReady = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ram[i] <= 32'h0;
      model_mem[i] = 32'h0;
    end
    ram[8]  <= 32'h801234F0; model_mem[8]  = 32'h801234F0;
    ram[12] <= 32'h11223344; model_mem[12] = 32'h11223344;

    repeat (3) @(posedge clk); #1;
    chk("rst_reqReady", {31'b0, reqReady}, 32'h0);
    chk("rst_rspValid", {31'b0, rspValid}, 32'h0);
    chk("rst_rspData", rspData, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_mem", {29'b0, memRead, memWrite}, 32'h0);
    chk("rst_memAddress", memAddress, 32'h0);
    @(negedge clk); resetN = 1'b1; #1;
    chk("ready_before_edge", {31'b0, reqReady}, 32'h0);
    @(posedge clk); #1;
    chk("ready_first_edge", {31'b0, reqReady}, 32'h1);
    live = 1'b1;

    // Word store then load.
    do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0, got, gm);
    chk("pin_store_rsp0", got, 32'h0);
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0, 1'b0, got, gm);
    chk("pin_load_word", got, 32'hDEADBEEF);

    // Lane extraction from 0x801234F0.
    do_req(1'b0, 2'b11, 1'b1, 32'h23, 32'h0, 0, 1'b0, got, gm);
    chk("pin_byte_signed", got, 32'hFFFFFF80);
    do_req(1'b0, 2'b11, 1'b0, 32'h23, 32'h0, 0, 1'b0, got, gm);
    chk("pin_byte_unsigned", got, 32'h00000080);
    do_req(1'b0, 2'b10, 1'b1, 32'h22, 32'h0, 0, 1'b0, got, gm);
    chk("pin_half_signed", got, 32'hFFFF8012);
    do_req(1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 0, 1'b0, got, gm);
    chk("pin_half_low", got, 32'h000034F0);
    do_req(1'b0, 2'b11, 1'b1, 32'h21, 32'h0, 0, 1'b0, got, gm);
    chk("pin_byte_off1", got, 32'h00000034);

    // Misaligned requests.
    do_req(1'b0, 2'b10, 1'b0, 32'h5, 32'h0, 0, 1'b0, got, gm);
    chk("pin_mis_half", {31'b0, gm}, 32'h1);
    do_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 0, 1'b0, got, gm);
    chk("pin_mis_size0", {31'b0, gm}, 32'h1);
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h55555555, 0, 1'b0, got, gm);
    chk("pin_mis_store_word", {31'b0, gm}, 32'h1);

    // Sub-word stores into 0x11223344.
    do_req(1'b1, 2'b11, 1'b0, 32'h31, 32'h000000AA, 0, 1'b0, got, gm);
    do_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 0, 1'b0, got, gm);
`ifdef LSU_RMW_EN
    chk("pin_rmw_byte", got, 32'h1122AA44);
`else
    chk("pin_nomerge_byte", got, 32'h11223344);
`endif
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h0000BEEF, 0, 1'b0, got, gm);
    do_req(1'b1, 2'b11, 1'b0, 32'h30, 32'hFFFFFF77, 0, 1'b0, got, gm);
    do_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 0, 1'b0, got, gm);
    chk("pin_sub_stores", got, 32'h1122BE77);
    do_req(1'b1, 2'b10, 1'b0, 32'h32, 32'h00005566, 0, 1'b0, got, gm);

    // Held response with a competing request while busy.
    do_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 5, 1'b1, got, gm);
    do_req(1'b0, 2'b10, 1'b0, 32'h32, 32'h0, 0, 1'b0, got, gm);

    // Reset during WRITE abandons the store.
    live = 1'b0;
    @(negedge clk); #2;
    reqWrite = 1'b1; reqSize = 2'b01; reqSigned = 1'b0; reqAddr = 32'h40; reqData = 32'h12345678;
    reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    chk("write_before_reset", {30'b0, memWrite}, 32'h1);
    #1 resetN = 1'b0;
    #1;
    chk("reset_kills_write", {30'b0, memWrite}, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);
    chk("reset_memAddress", memAddress, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); resetN = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'b0, reqReady}, 32'h1);
    rv_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rspValid) rv_cnt++;
    end
    chk("no_rsp_after_reset", rv_cnt, 0);
    chk("abandoned_store", ram[16], 32'h0);
    live = 1'b1;

    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0, 1'b0, got, gm);
    chk("pin_load_after_reset", got, 32'hDEADBEEF);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
